mem_ctrl: RTL and testbench

Memory controller that shares the single byte-wide RAM port between the instruction-fetch side (the I-cache miss path) and the data side (load/store unit). It arbitrates between the two requesters, serialises each 1/2/4-byte access into byte-wide RAM cycles, and assembles little-endian read words. Both requesters see one `busy` signal and a one-cycle `ready` pulse.

---
 rtl/mem_ctrl.sv | 141 ++++++++++++++
 tb/tb_mem_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Shares one byte-wide RAM port between instruction fetch and the load/store unit,
// serialising 1/2/4-byte accesses. Optional round-robin arbitration: `MEM_CTRL_RR_EN.
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_read,
  input  logic [31:0]       i_addr,
  output logic              i_ready,
  output logic [31:0]       i_data,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_addr,
  input  logic [1:0]        d_len,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  input  logic [7:0]        mem_din
);

  typedef enum logic [1:0] {IDLE, RUN, TAIL, DONE} state_t;

  state_t            state_q, state_d;
  logic              port_q, port_d;     // 1 = data port owns the transaction
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        k_q, k_d;
  logic [1:0]        last_k_q, last_k_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       i_data_q, i_data_d;
  logic [31:0]       d_rdata_q, d_rdata_d;

  logic d_req;
  logic grant_d;
  logic unused_addr_hi;

  assign d_req          = d_read | d_write;
  assign unused_addr_hi = ^{i_addr[31:ADDR_W], d_addr[31:ADDR_W]};

`ifdef MEM_CTRL_RR_EN
  // Remembers the winner of the most recent conflict; 0 = instruction.
  logic last_q, last_d;

  assign grant_d = d_req & (~i_read | ~last_q);

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && d_req && i_read) last_d = grant_d;
  end

  always_ff @(posedge clock) begin
    if (reset) last_q <= 1'b0;
    else       last_q <= last_d;
  end
`else
  assign grant_d = d_req;
`endif

  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    k_d       = k_q;
    last_k_d  = last_k_q;
    wdata_d   = wdata_q;
    buf_d     = buf_q;
    i_data_d  = i_data_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (d_req || i_read) begin
          state_d  = RUN;
          port_d   = grant_d;
          wr_d     = grant_d & d_write;
          addr_d   = grant_d ? d_addr[ADDR_W-1:0] : i_addr[ADDR_W-1:0];
          last_k_d = !grant_d ? 2'd3 : (d_len == 2'd0) ? 2'd0 : (d_len == 2'd1) ? 2'd1 : 2'd3;
          k_d      = 2'd0;
          wdata_d  = d_wdata;
          buf_d    = 32'h0;
        end
      end
      RUN: begin
        // RAM data lags the address by one cycle, so byte k-1 arrives now.
        if (!wr_q && k_q != 2'd0) buf_d[{k_q - 2'd1, 3'b000} +: 8] = mem_din;
        if (k_q == last_k_q) state_d = wr_q ? DONE : TAIL;
        else                 k_d = k_q + 2'd1;
      end
      TAIL: begin
        buf_d[{last_k_q, 3'b000} +: 8] = mem_din;
        if (port_q) d_rdata_d = buf_d;
        else        i_data_d  = buf_d;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      port_q    <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      k_q       <= 2'd0;
      last_k_q  <= 2'd0;
      wdata_q   <= 32'h0;
      buf_q     <= 32'h0;
      i_data_q  <= 32'h0;
      d_rdata_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      k_q       <= k_d;
      last_k_q  <= last_k_d;
      wdata_q   <= wdata_d;
      buf_q     <= buf_d;
      i_data_q  <= i_data_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign i_ready  = (state_q == DONE) & ~port_q;
  assign d_ready  = (state_q == DONE) & port_q;
  assign i_data   = i_data_q;
  assign d_rdata  = d_rdata_q;
  assign mem_a    = (state_q == RUN) ? addr_q + ADDR_W'(k_q) : '0;
  assign mem_wr   = (state_q == RUN) & wr_q;
  assign mem_dout = mem_wr ? wdata_q[{k_q, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte RAM model and per-port ready scoreboards.
module tb_mem_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_read = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic        i_ready;
  logic [31:0] i_data;
  logic        d_read = 1'b0, d_write = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [1:0]  d_len = 2'd0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        busy;
  logic [16:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;

  int checks = 0;
  int errors = 0;
  int cnt    = 0;

`ifdef MEM_CTRL_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } ent_t;
  ent_t iq[$];
  ent_t dq[$];

  logic [7:0]  ram [0:131071];
  logic        bd_we = 1'b0;
  logic [16:0] bd_a = '0;
  logic [7:0]  bd_d = '0;

  mem_ctrl #(.ADDR_W(17)) dut (
    .clock(clock), .reset(reset),
    .i_read(i_read), .i_addr(i_addr), .i_ready(i_ready), .i_data(i_data),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_len(d_len),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .busy(busy), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cnt <= cnt + 1;
    if (bd_we)       ram[bd_a] <= bd_d;
    else if (mem_wr) ram[mem_a] <= mem_dout;
    mem_din <= ram[mem_a];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    ent_t e;
    if (i_ready) begin
      if (iq.size() == 0) check("i_ready_unexpected", {31'b0, i_ready}, 32'h0);
      else begin
        e = iq.pop_front();
        check("i_data", i_data, e.data);
        check("i_ready_cycle", cnt, e.cyc);
      end
    end
    if (d_ready) begin
      if (dq.size() == 0) check("d_ready_unexpected", {31'b0, d_ready}, 32'h0);
      else begin
        e = dq.pop_front();
        check("d_rdata", d_rdata, e.data);
        check("d_ready_cycle", cnt, e.cyc);
      end
    end
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic poke(input logic [16:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_a = a; bd_d = d;
    step();
    bd_we = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    if (busy) check("idle_timeout", {31'b0, busy}, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'h0);
    check({tag, "_i_ready"}, {31'b0, i_ready}, 32'h0);
    check({tag, "_d_ready"}, {31'b0, d_ready}, 32'h0);
    check({tag, "_i_data"}, i_data, 32'h0);
    check({tag, "_d_rdata"}, d_rdata, 32'h0);
    check({tag, "_mem_a"}, {15'b0, mem_a}, 32'h0);
    check({tag, "_mem_dout"}, {24'b0, mem_dout}, 32'h0);
    check({tag, "_mem_wr"}, {31'b0, mem_wr}, 32'h0);
  endtask

  // Drives a data request for one cycle; called at a negedge, returns in cycle 1.
  task automatic issue_d(input logic rd, input logic wr, input logic [31:0] a, input logic [1:0] len,
                         input logic [31:0] wd, input int lat, input logic [31:0] exp);
    d_read = rd; d_write = wr; d_addr = a; d_len = len; d_wdata = wd;
    dq.push_back('{data: exp, cyc: cnt + lat});
    step();
    d_read = 1'b0; d_write = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] drd;
    int n0;
    drd = 32'h0;

    poke(17'h00100, 8'h13); poke(17'h00101, 8'h05);
    poke(17'h00102, 8'h10); poke(17'h00103, 8'h00);
    poke(17'h00022, 8'h77); poke(17'h00023, 8'h00);
    poke(17'h1FFFF, 8'h11); poke(17'h00000, 8'h22);
    poke(17'h00001, 8'h33); poke(17'h00002, 8'h44);
    poke(17'h00042, 8'hEE); poke(17'h00043, 8'hEE);
    check_all_zero("reset");
    reset = 1'b0;
    step();

    // Fetch of a word; busy high in cycles 1..6.
    i_read = 1'b1; i_addr = 32'h100;
    iq.push_back('{data: 32'h00100513, cyc: cnt + 6});
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 1) i_read = 1'b0;
      check("fetch_busy", {31'b0, busy}, (c <= 6) ? 32'h1 : 32'h0);
    end
    wait_idle();

    // Half store, then half and byte loads.
    issue_d(1'b0, 1'b1, 32'h20, 2'd1, 32'hAABBCCDD, 3, drd);
    wait_idle();
    check("ram_20", {24'b0, ram[32'h20]}, 32'hDD);
    check("ram_21", {24'b0, ram[32'h21]}, 32'hCC);
    check("ram_22_untouched", {24'b0, ram[32'h22]}, 32'h77);
    drd = 32'h0000CCDD;
    issue_d(1'b1, 1'b0, 32'h20, 2'd1, 32'h0, 4, drd);
    wait_idle();
    drd = 32'h00000077;
    issue_d(1'b1, 1'b0, 32'h22, 2'd0, 32'h0, 3, drd);
    wait_idle();

    // First conflict: data wins; fetch accepted after data DONE + 1.
    drd = 32'h0077CCDD;
    n0 = cnt;
    i_read = 1'b1; i_addr = 32'h100;
    d_read = 1'b1; d_addr = 32'h20; d_len = 2'd2;
    dq.push_back('{data: drd, cyc: n0 + 6});
    iq.push_back('{data: 32'h00100513, cyc: n0 + 13});
    step();
    d_read = 1'b0;
    repeat (7) step();
    i_read = 1'b0;
    wait_idle();

    // Second conflict: fetch wins only with round-robin.
    n0 = cnt;
    i_read = 1'b1; d_read = 1'b1;
    if (RR) begin
      iq.push_back('{data: 32'h00100513, cyc: n0 + 6});
      dq.push_back('{data: drd, cyc: n0 + 13});
      step();
      i_read = 1'b0;
      repeat (7) step();
      d_read = 1'b0;
    end else begin
      dq.push_back('{data: drd, cyc: n0 + 6});
      iq.push_back('{data: 32'h00100513, cyc: n0 + 13});
      step();
      d_read = 1'b0;
      repeat (7) step();
      i_read = 1'b0;
    end
    wait_idle();

    // Word read wrapping past the top of the RAM.
    drd = 32'h44332211;
    d_read = 1'b1; d_addr = 32'h1FFFF; d_len = 2'd2;
    dq.push_back('{data: drd, cyc: cnt + 6});
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) d_read = 1'b0;
      check("wrap_mem_a", {15'b0, mem_a}, (c <= 4) ? ((32'h1FFFF + 32'(c - 1)) & 32'h1FFFF) : 32'h0);
    end
    wait_idle();

    // Reset during a word write: reset edge begins cycle 3, so two bytes land.
    d_write = 1'b1; d_addr = 32'h40; d_len = 2'd2; d_wdata = 32'h04030201;
    step();
    d_write = 1'b0;
    step();
    reset = 1'b1;
    step();
    check_all_zero("midreset");
    reset = 1'b0;
    drd = 32'h00000002;
    issue_d(1'b1, 1'b0, 32'h41, 2'd0, 32'h0, 3, drd);
    wait_idle();
    check("ram_40", {24'b0, ram[32'h40]}, 32'h01);
    check("ram_41", {24'b0, ram[32'h41]}, 32'h02);
    check("ram_42_untouched", {24'b0, ram[32'h42]}, 32'hEE);
    check("ram_43_untouched", {24'b0, ram[32'h43]}, 32'hEE);

    // Read and write together: write wins, d_rdata keeps its value.
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h50; d_len = 2'd0; d_wdata = 32'h000000A5;
    dq.push_back('{data: drd, cyc: cnt + 2});
    step();
    check("rw_mem_wr_c1", {31'b0, mem_wr}, 32'h1);
    d_read = 1'b0; d_write = 1'b0;
    step();
    check("rw_mem_wr_c2", {31'b0, mem_wr}, 32'h0);
    wait_idle();
    check("ram_50", {24'b0, ram[32'h50]}, 32'hA5);

    repeat (4) step();
    check("iq_drained", iq.size(), 32'h0);
    check("dq_drained", dq.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
